anemometer_pulse_conditioner: RTL and testbench

Front end of the wind-speed path. It takes the raw reed-switch signal from the cup anemometer and produces three things for the downstream speed calculator:
- a clean one-cycle rotation pulse (synchronised and debounced);
- a periodic measurement-gate tick;
- a latched per-gate rotation count.

It sits between the board input pin and the speed-computation stage.

---
 rtl/anemometer_pulse_conditioner.sv | 108 ++++++++++
 tb/tb_anemometer_pulse_conditioner.sv | 136 +++++++++++++
 2 files changed

// File: rtl/anemometer_pulse_conditioner.sv
// anemometer_pulse_conditioner: sync + debounce reed switch, gate windows, latch per-window rotation count
module anemometer_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int GATE_CYCLES     = 50000000,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reed_in,
  input  logic               enable,
  output logic               rotation_pulse,
  output logic               gate_tick,
  output logic [COUNT_W-1:0] pulse_count,
  output logic               count_valid,
  output logic               overflow
);
  localparam int DW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int GW = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {LOW_STABLE, CHK_HIGH, HIGH_STABLE, CHK_LOW} state_t;

  state_t             state;
  logic               s1, sync_level;
  logic [DW-1:0]      dcnt;
  logic [GW-1:0]      gcnt;
  logic [COUNT_W-1:0] wcnt, wnext;
  logic               sat, snext, hit, at_max;

  // two-flop synchroniser; only sync_level is used downstream
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync_level, s1} <= 2'b00;
    else {sync_level, s1} <= {s1, reed_in};

  // debounce FSM: a level must hold DEBOUNCE_CYCLES before acceptance; pulse on accepted rise
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= LOW_STABLE;
      dcnt <= '0;
      rotation_pulse <= 1'b0;
    end else begin
      rotation_pulse <= 1'b0;
      case (state)
        LOW_STABLE:
          if (sync_level) begin
            state <= CHK_HIGH;
            dcnt <= DW'(1);
          end
        CHK_HIGH:
          if (!sync_level) begin
            state <= LOW_STABLE;
            dcnt <= '0;
          end else if (dcnt == DMAX) begin
            state <= HIGH_STABLE;
            dcnt <= '0;
            rotation_pulse <= 1'b1;
          end else dcnt <= dcnt + 1'b1;
        HIGH_STABLE:
          if (!sync_level) begin
            state <= CHK_LOW;
            dcnt <= DW'(1);
          end
        CHK_LOW:
          if (sync_level) begin
            state <= HIGH_STABLE;
            dcnt <= '0;
          end else if (dcnt == DMAX) begin
            state <= LOW_STABLE;
            dcnt <= '0;
          end else dcnt <= dcnt + 1'b1;
        default: state <= LOW_STABLE;
      endcase
    end

  assign gate_tick = enable && gcnt == GLAST;

  // gate counter: free-runs 0..GATE_CYCLES-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk or posedge reset)
    if (reset) gcnt <= '0;
    else gcnt <= (!enable || gate_tick) ? '0 : gcnt + 1'b1;

  // next window count/sat including a pulse in this cycle, so a tick-coincident pulse is kept
  always_comb begin
    hit = rotation_pulse && enable;
    at_max = &wcnt;
    wnext = (hit && !at_max) ? wcnt + 1'b1 : wcnt;
    snext = sat || (hit && at_max);
  end

  // window accumulation and end-of-window latch
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wcnt <= '0;
      sat <= 1'b0;
      pulse_count <= '0;
      overflow <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= gate_tick;
      wcnt <= (!enable || gate_tick) ? '0 : wnext;
      sat <= (!enable || gate_tick) ? 1'b0 : snext;
      if (gate_tick) begin
        pulse_count <= wnext;
        overflow <= snext;
      end
    end
endmodule

// File: tb/tb_anemometer_pulse_conditioner.sv
// tb_anemometer_pulse_conditioner: directed checks of debounce latency, gating, counting and saturation
module tb_anemometer_pulse_conditioner;
  logic       clk, reset;
  logic       reed_a, en_a, rp_a, gt_a, cv_a, ov_a;
  logic [7:0] pc_a;
  logic       reed_b, en_b, rp_b, gt_b, cv_b, ov_b;
  logic [2:0] pc_b;
  int         n_cmp = 0;
  int         n_err = 0;

  anemometer_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .GATE_CYCLES(100), .COUNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .reed_in(reed_a), .enable(en_a),
    .rotation_pulse(rp_a), .gate_tick(gt_a), .pulse_count(pc_a),
    .count_valid(cv_a), .overflow(ov_a)
  );

  anemometer_pulse_conditioner #(.DEBOUNCE_CYCLES(2), .GATE_CYCLES(200), .COUNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .reed_in(reed_b), .enable(en_b),
    .rotation_pulse(rp_b), .gate_tick(gt_b), .pulse_count(pc_b),
    .count_valid(cv_b), .overflow(ov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int c, input logic rp, gt, cv, ov, input logic [7:0] pc);
    chk({tag, ".rp"}, c, rp_a, rp);
    chk({tag, ".gt"}, c, gt_a, gt);
    chk({tag, ".cv"}, c, cv_a, cv);
    chk({tag, ".ov"}, c, ov_a, ov);
    chk({tag, ".pc"}, c, pc_a, pc);
  endtask

  initial begin
    reset = 1'b1;
    reed_a = 1'b0; en_a = 1'b0;
    reed_b = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_a("rst_a", 0, 0, 0, 0, 0, 0);
    chk("rst_b.pc", 0, pc_b, 0);
    chk("rst_b.ov", 0, ov_b, 0);
    chk("rst_b.cv", 0, cv_b, 0);
    @(negedge clk);
    reset = 1'b0;

    // idle input, enabled: empty windows reported at 100 and 200
    for (int c = 1; c <= 201; c++) begin
      en_a = 1'b1;
      #1;
      chk_a("idle", c, 0, c == 100 || c == 200, c == 101 || c == 201, 0, 0);
      @(negedge clk);
    end
    en_a = 1'b0;

    // clean press: pulse 7 edges after first sampling edge, none on release
    for (int c = 1; c <= 40; c++) begin
      reed_a = c <= 20;
      #1;
      chk("clean.rp", c, rp_a, c == 8);
      chk("clean.pc", c, pc_a, 0);
      @(negedge clk);
    end

    // 3-high/2-low chatter yields nothing; final steady rise at 41 pulses at 48
    for (int c = 1; c <= 80; c++) begin
      reed_a = c <= 40 ? ((c - 1) % 5) < 3 : c <= 60;
      #1;
      chk("chatter.rp", c, rp_a, c == 48);
      @(negedge clk);
    end

    // 5 rotations per window, 5th pulse lands on each tick
    for (int c = 1; c <= 202; c++) begin
      en_a = 1'b1;
      reed_a = c >= 13 && ((c - 13) % 20) < 10;
      #1;
      chk_a("win", c, c >= 20 && c <= 200 && ((c - 20) % 20) == 0,
            c == 100 || c == 200, c == 101 || c == 201, 0, c <= 100 ? 8'd0 : 8'd5);
      @(negedge clk);
    end
    en_a = 1'b0;
    reed_a = 1'b0;

    // 3-bit count saturates at 7 with overflow, next window reports 2 clean
    for (int c = 1; c <= 402; c++) begin
      en_b = 1'b1;
      reed_b = ((c >= 2 && c <= 121) || (c >= 206 && c <= 229)) && ((c - 2) % 12) < 6;
      #1;
      chk("sat.rp", c, rp_b, (c >= 7 && c <= 115 && ((c - 7) % 12) == 0) || c == 211 || c == 223);
      chk("sat.gt", c, gt_b, c == 200 || c == 400);
      chk("sat.cv", c, cv_b, c == 201 || c == 401);
      chk("sat.pc", c, pc_b, c <= 200 ? 0 : c <= 400 ? 7 : 2);
      chk("sat.ov", c, ov_b, c > 200 && c <= 400);
      @(negedge clk);
    end
    en_b = 1'b0;
    reed_b = 1'b0;

    // async reset mid-window discards 3 counted rotations
    for (int c = 1; c <= 52; c++) begin
      en_a = 1'b1;
      reed_a = c >= 2 && c <= 36 && ((c - 2) % 14) < 7;
      reset = c >= 50;
      #1;
      if (c < 50) chk_a("pre", c, c == 9 || c == 23 || c == 37, 0, 0, 0, 5);
      else chk_a("inrst", c, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    reset = 1'b0;
    reed_a = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      en_a = 1'b0;
      #1;
      chk_a("hold", c, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    for (int c = 1; c <= 101; c++) begin
      en_a = 1'b1;
      #1;
      chk_a("restart", c, 0, c == 100, c == 101, 0, 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
